// File: rtl/bus_tx_queue_if.sv
// Producer handshake and bus-slot signals of one transmit queue.
// The queue takes the slave view; whoever drives it takes the master view.
interface bus_tx_queue_if #(
    parameter int unsigned WIDTH = 10
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic [WIDTH-1:0] bus_message;
    logic             bus_write;
    logic             bus_sent;

    modport slave (
        input  in_valid,
        input  in_data,
        input  bus_sent,
        output in_ready,
        output bus_message,
        output bus_write
    );

    modport master (
        output in_valid,
        output in_data,
        output bus_sent,
        input  in_ready,
        input  bus_message,
        input  bus_write
    );
endinterface

// File: rtl/bus_tx_queue.sv
// Per-client transmit FIFO feeding one slot of the round-robin bus.
// Head is shown on bus_message/bus_write and retired by the bus_sent pulse.
module bus_tx_queue #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    bus_tx_queue_if.slave              q_if,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic [$clog2(DEPTH+1)-1:0] peak_level,
    output logic                       err_spurious
);
    localparam int unsigned LW = $clog2(DEPTH + 1);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_rd_ptr;
    logic [PW-1:0]    r_wr_ptr;
    logic [LW-1:0]    r_level;
    logic [LW-1:0]    r_peak;
    logic             r_err;

    logic             w_not_empty;
    logic             w_not_full;
    logic             w_push;
    logic             w_pop;
    logic [LW-1:0]    w_level_nxt;

    // Handshake decode depends on registered occupancy only
    assign w_not_empty = (r_level != LW'(0));
    assign w_not_full  = (r_level != LW'(DEPTH));
    assign w_push      = q_if.in_valid & w_not_full;
    assign w_pop       = q_if.bus_sent & w_not_empty;

    always_comb begin
        w_level_nxt = r_level;
        if (w_push && !w_pop) begin
            w_level_nxt = r_level + LW'(1);
        end else if (w_pop && !w_push) begin
            w_level_nxt = r_level - LW'(1);
        end
    end

    // Control state; a bus_sent arriving during reset is dropped
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_level  <= '0;
            r_peak   <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == PW'(DEPTH - 1)) ? '0 : r_rd_ptr + PW'(1);
            end
            r_level <= w_level_nxt;
            r_peak  <= (w_level_nxt > r_peak) ? w_level_nxt : r_peak;
            if (q_if.bus_sent && !w_not_empty) begin
                r_err <= 1'b1;
            end
        end
    end

    // Storage is intentionally not cleared by reset
    always_ff @(posedge clock) begin
        if (w_push && !reset) begin
            r_mem[r_wr_ptr] <= q_if.in_data;
        end
    end

    assign q_if.in_ready    = w_not_full;
    assign q_if.bus_write   = w_not_empty;
    assign q_if.bus_message = r_mem[r_rd_ptr];
    assign level            = r_level;
    assign peak_level       = r_peak;
    assign err_spurious     = r_err;
endmodule

// File: tb/tb_bus_tx_queue.sv
// Directed bench for bus_tx_queue: per-cycle vector table plus a
// scoreboarded multi-client streaming sequence.
module tb_bus_tx_queue;
    localparam int unsigned WIDTH = 10;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned LW    = $clog2(DEPTH + 1);

    logic          clock;
    logic          reset;
    logic [LW-1:0] level;
    logic [LW-1:0] peak_level;
    logic          err_spurious;

    bus_tx_queue_if #(.WIDTH(WIDTH)) q_if ();

    bus_tx_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clock       (clock),
        .reset       (reset),
        .q_if        (q_if),
        .level       (level),
        .peak_level  (peak_level),
        .err_spurious(err_spurious)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic             rst;
        logic             vld;
        logic [WIDTH-1:0] dat;
        logic             snt;
        int               e_lvl;
        logic             e_wr;
        logic             e_rdy;
        logic [WIDTH-1:0] e_msg;
        int               e_pk;
        logic             e_err;
    } vec_t;

    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input int idx, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s [%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic add(input logic rst, input logic vld, input logic [WIDTH-1:0] dat,
                       input logic snt, input int lvl, input logic wr, input logic rdy,
                       input logic [WIDTH-1:0] msg, input int pk, input logic er);
        vec_t v;
        v.rst = rst; v.vld = vld; v.dat = dat; v.snt = snt;
        v.e_lvl = lvl; v.e_wr = wr; v.e_rdy = rdy; v.e_msg = msg;
        v.e_pk = pk; v.e_err = er;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic rst, input logic vld, input logic [WIDTH-1:0] dat,
                         input logic snt);
        reset         = rst;
        q_if.in_valid = vld;
        q_if.in_data  = dat;
        q_if.bus_sent = snt;
    endtask

    // Streaming sequence state
    logic [WIDTH-1:0] sb[$];
    int               cnt;
    int               pushed;
    int               received;
    int               phase;
    logic             sent_pend;
    logic             vld_now;
    logic             snt_now;
    logic             acc;

    initial begin
        drive(1'b1, 1'b0, '0, 1'b0);

        // rst vld dat snt | lvl wr rdy msg pk err
        add(1, 0, 10'h000, 0,  0, 0, 1, 10'h000, 0, 0);
        // single message through an idle client
        add(0, 1, 10'h155, 0,  1, 1, 1, 10'h155, 1, 0);
        add(0, 0, 10'h000, 0,  1, 1, 1, 10'h155, 1, 0);   // grant edge
        add(0, 0, 10'h000, 1,  0, 0, 1, 10'h000, 1, 0);   // sent cycle pops
        // fill past full, fifth push rejected
        add(0, 1, 10'h001, 0,  1, 1, 1, 10'h001, 1, 0);
        add(0, 1, 10'h002, 0,  2, 1, 1, 10'h001, 2, 0);
        add(0, 1, 10'h003, 0,  3, 1, 1, 10'h001, 3, 0);
        add(0, 1, 10'h004, 0,  4, 1, 0, 10'h001, 4, 0);
        add(0, 1, 10'h005, 0,  4, 1, 0, 10'h001, 4, 0);
        // full queue rejects a push even in a pop cycle
        add(0, 1, 10'h006, 1,  3, 1, 1, 10'h002, 4, 0);
        for (int i = 0; i < 3; i++) add(0, 0, 10'h000, 0, 3, 1, 1, 10'h002, 4, 0);
        add(0, 0, 10'h000, 1,  2, 1, 1, 10'h003, 4, 0);
        for (int i = 0; i < 3; i++) add(0, 0, 10'h000, 0, 2, 1, 1, 10'h003, 4, 0);
        add(0, 0, 10'h000, 1,  1, 1, 1, 10'h004, 4, 0);
        for (int i = 0; i < 3; i++) add(0, 0, 10'h000, 0, 1, 1, 1, 10'h004, 4, 0);
        add(0, 0, 10'h000, 1,  0, 0, 1, 10'h000, 4, 0);
        // push coinciding with the sent cycle at level 1
        add(0, 1, 10'h0AA, 0,  1, 1, 1, 10'h0AA, 4, 0);
        add(0, 1, 10'h0BB, 1,  1, 1, 1, 10'h0BB, 4, 0);
        add(0, 0, 10'h000, 0,  1, 1, 1, 10'h0BB, 4, 0);
        add(0, 0, 10'h000, 1,  0, 0, 1, 10'h000, 4, 0);
        // spurious sent while empty is sticky
        add(0, 0, 10'h000, 1,  0, 0, 1, 10'h000, 4, 1);
        add(0, 0, 10'h000, 0,  0, 0, 1, 10'h000, 4, 1);
        add(0, 1, 10'h0CC, 0,  1, 1, 1, 10'h0CC, 4, 1);
        add(0, 0, 10'h000, 1,  0, 0, 1, 10'h000, 4, 1);
        // reset lands on the sent cycle with level 2
        add(0, 1, 10'h011, 0,  1, 1, 1, 10'h011, 4, 1);
        add(0, 1, 10'h022, 0,  2, 1, 1, 10'h011, 4, 1);
        add(1, 0, 10'h000, 1,  0, 0, 1, 10'h000, 0, 0);
        add(0, 1, 10'h033, 0,  1, 1, 1, 10'h033, 1, 0);
        add(0, 0, 10'h000, 1,  0, 0, 1, 10'h000, 1, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].vld, vecs[i].dat, vecs[i].snt);
            @(posedge clock);
            #1;
            chk("level", i, int'(level), vecs[i].e_lvl);
            chk("bus_write", i, int'(q_if.bus_write), int'(vecs[i].e_wr));
            chk("in_ready", i, int'(q_if.in_ready), int'(vecs[i].e_rdy));
            chk("peak_level", i, int'(peak_level), vecs[i].e_pk);
            chk("err_spurious", i, int'(err_spurious), int'(vecs[i].e_err));
            if (vecs[i].e_wr) chk("bus_message", i, int'(q_if.bus_message), int'(vecs[i].e_msg));
        end

        // Steady producer, slot granted every 3 cycles (3 active clients)
        drive(1'b1, 1'b0, '0, 1'b0);
        @(posedge clock);
        #1;
        cnt = 0; pushed = 0; received = 0; phase = 0; sent_pend = 1'b0;
        for (int cyc = 0; cyc < 300 && received < 10; cyc++) begin
            snt_now   = sent_pend;
            sent_pend = 1'b0;
            if (phase == 0 && cnt > 0 && !snt_now) begin
                chk("stream_msg", received, int'(q_if.bus_message), int'(sb[0]));
                sent_pend = 1'b1;
            end
            phase   = (phase == 2) ? 0 : phase + 1;
            vld_now = (pushed < 10);
            acc     = vld_now && (cnt != DEPTH);
            drive(1'b0, vld_now, WIDTH'(10'h200 + pushed), snt_now);
            @(posedge clock);
            #1;
            if (acc) begin
                sb.push_back(WIDTH'(10'h200 + pushed));
                pushed++;
                cnt++;
            end
            if (snt_now && cnt > 0) begin
                void'(sb.pop_front());
                received++;
                cnt--;
            end
            chk("stream_level", cyc, int'(level), cnt);
            chk("stream_ready", cyc, int'(q_if.in_ready), int'(cnt != DEPTH));
        end
        drive(1'b0, 1'b0, '0, 1'b0);
        chk("stream_received", 0, received, 10);
        chk("stream_empty", 0, int'(q_if.bus_write), 0);
        chk("stream_peak", 0, int'(peak_level), DEPTH);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
